instr_fetch: RTL and testbench

//  Instruction fetch stage feeding the register file's PC path and the decoder.

---
 rtl/instr_fetch.sv | 159 +++++++++++++++
 tb/tb_instr_fetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the reset vector, then fetches opcode plus
// extension words and hands one complete instruction to the decoder.
module instr_fetch #(
  parameter logic [15:0] VEC_ADDR = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic [15:0] reg_PC_in,
  output logic [15:0] RST_VEC,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] ir,
  output logic [15:0] ext1,
  output logic [15:0] ext2,
  output logic [1:0]  n_ext
);

  typedef enum logic [1:0] {S_VEC, S_OP, S_EXT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] rst_vec_q, rst_vec_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ext1_q, ext1_d;
  logic [15:0] ext2_q, ext2_d;
  logic [1:0]  n_ext_q, n_ext_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        flush_q, flush_d;
  logic        ack;
  logic        load;
  logic [1:0]  need;
  logic [1:0]  cnt_inc;

  function automatic logic src_ext(input logic [1:0] mode, input logic [3:0] rs);
    return ((mode == 2'b01) && (rs != 4'd3)) || ((mode == 2'b11) && (rs == 4'd0));
  endfunction

  function automatic logic [1:0] ext_need(input logic [15:0] w);
    logic [1:0] n;
    n = 2'd0;
    if (w[15:13] == 3'b001) begin
      n = 2'd0;
    end else if (w[15:10] == 6'b000100) begin
      n = {1'b0, src_ext(w[5:4], w[3:0])};
    end else if (w[15:12] >= 4'd4) begin
      n = {1'b0, src_ext(w[5:4], w[11:8])} + {1'b0, w[7]};
    end
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    rst_vec_d = rst_vec_q;
    ir_d      = ir_q;
    ext1_d    = ext1_q;
    ext2_d    = ext2_q;
    n_ext_d   = n_ext_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    flush_d   = flush_q;
    ack       = req_q && mem_ack;
    load      = pc_load && (state_q != S_VEC);
    need      = ext_need(mem_rdata);
    cnt_inc   = cnt_q + 2'd1;

    if (load) begin
      pc_d    = pc_target & 16'hFFFE;
      state_d = S_OP;
      cnt_d   = 2'd0;
      // A read already on the bus must complete; its data is dropped on arrival.
      flush_d = req_q && !mem_ack;
    end else if (ack && flush_q) begin
      flush_d = 1'b0;
    end else begin
      case (state_q)
        S_VEC: if (ack) begin
          rst_vec_d = mem_rdata;
          pc_d      = {mem_rdata[15:1], 1'b0};
          state_d   = S_OP;
        end
        S_OP: if (ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd2;
          n_ext_d = need;
          cnt_d   = 2'd0;
          state_d = (need == 2'd0) ? S_HOLD : S_EXT;
        end
        S_EXT: if (ack) begin
          if (cnt_q == 2'd0) ext1_d = mem_rdata;
          else               ext2_d = mem_rdata;
          pc_d  = pc_q + 16'd2;
          cnt_d = cnt_inc;
          if (cnt_inc == n_ext_q) state_d = S_HOLD;
        end
        S_HOLD: if (instr_ready) state_d = S_OP;
        default: state_d = S_VEC;
      endcase
    end

    // Request/address are frozen while a read is unacknowledged.
    if (!(req_q && !mem_ack)) begin
      if (state_d == S_HOLD) begin
        req_d = 1'b0;
      end else begin
        req_d  = 1'b1;
        addr_d = (state_d == S_VEC) ? VEC_ADDR : pc_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_VEC;
      pc_q      <= 16'h0000;
      addr_q    <= VEC_ADDR;
      rst_vec_q <= 16'h0000;
      ir_q      <= 16'h0000;
      ext1_q    <= 16'h0000;
      ext2_q    <= 16'h0000;
      n_ext_q   <= 2'd0;
      cnt_q     <= 2'd0;
      req_q     <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      rst_vec_q <= rst_vec_d;
      ir_q      <= ir_d;
      ext1_q    <= ext1_d;
      ext2_q    <= ext2_d;
      n_ext_q   <= n_ext_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign reg_PC_in   = pc_q;
  assign RST_VEC     = rst_vec_q;
  assign instr_valid = (state_q == S_HOLD);
  assign ir          = ir_q;
  assign ext1        = ext1_q;
  assign ext2        = ext2_q;
  assign n_ext       = n_ext_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-randomised program memory, random decoder
// backpressure and redirects, checked against an instruction-stream model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [15:0] reg_PC_in;
  logic [15:0] RST_VEC;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] ir, ext1, ext2;
  logic [1:0]  n_ext;

  always #5 clk = ~clk;

  instr_fetch #(.VEC_ADDR(16'hFFFE)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_load(pc_load), .pc_target(pc_target),
    .reg_PC_in(reg_PC_in), .RST_VEC(RST_VEC),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .ir(ir), .ext1(ext1), .ext2(ext2), .n_ext(n_ext)
  );

  typedef struct {
    logic [15:0] ir;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] next_pc;
    int          n;
  } exp_t;

  logic [15:0] mem [0:32767];
  logic [15:0] addr_log[$];
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_pc;
  logic        load_prev;
  logic [15:0] load_tgt;
  int          passed = 0;
  int          total  = 0;
  int          mem_cnt, mem_lat;
  logic [15:0] mem_first;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference decode: how many extension words an opcode word brings along.
  function automatic int need_of(input logic [15:0] w);
    bit src;
    if (w[15:13] == 3'b001) return 0;
    if (w[15:10] == 6'b000100) begin
      src = (w[5:4] == 2'b01 && w[3:0] != 4'd3) || (w[5:4] == 2'b11 && w[3:0] == 4'd0);
      return src ? 1 : 0;
    end
    if (w[15:12] >= 4'd4) begin
      src = (w[5:4] == 2'b01 && w[11:8] != 4'd3) || (w[5:4] == 2'b11 && w[11:8] == 4'd0);
      return (src ? 1 : 0) + (w[7] ? 1 : 0);
    end
    return 0;
  endfunction

  task automatic push_instr();
    exp_t e;
    logic [15:0] p;
    p = model_pc;
    e.ir = mem[p[15:1]];
    e.n  = need_of(e.ir);
    p = p + 16'd2;
    e.e1 = mem[p[15:1]];
    if (e.n >= 1) p = p + 16'd2;
    e.e2 = mem[p[15:1]];
    if (e.n == 2) p = p + 16'd2;
    e.next_pc = p;
    model_pc  = p;
    sb.push_back(e);
  endtask

  task automatic model_restart(input logic [15:0] pc);
    sb.delete();
    model_pc = pc & 16'hFFFE;
    while (sb.size() < 3) push_instr();
  endtask

  task automatic step();
    @(posedge clk); #2;
    if (load_prev) begin
      model_restart(load_tgt);
      load_prev = 1'b0;
    end
    while (sb.size() < 3) push_instr();
  endtask

  task automatic drive(input logic rdy, input logic ld, input logic [15:0] tgt);
    instr_ready = rdy;
    pc_load     = ld;
    pc_target   = tgt;
    if (ld) begin
      load_prev = 1'b1;
      load_tgt  = tgt;
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !instr_valid; i++) begin
      step();
      drive(1'b0, 1'b0, 16'h0);
    end
    if (!instr_valid) begin
      total++;
      $display("FAIL %s: instr_valid still 0 after %0d cycles, expected 1", name, budget);
    end
  endtask

  // Program memory: 1..3 cycle latency, one-cycle ack, protocol watch.
  initial begin
    mem_ack = 1'b0; mem_rdata = 16'h0; mem_cnt = 0; mem_lat = 1; mem_first = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          mem_cnt = 0;
        end
        if (mem_req) begin
          if (mem_cnt == 0) begin
            mem_lat   = $urandom_range(1, 3);
            mem_first = mem_addr;
            addr_log.push_back(mem_addr);
            check("addr_even", {15'd0, mem_addr[0]}, 16'd0);
          end else begin
            check("addr_stable", mem_addr, mem_first);
          end
          mem_cnt++;
          if (mem_cnt > mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[15:1]];
          end
        end else if (mem_cnt != 0) begin
          total++;
          $display("FAIL req_dropped: mem_req 0 before ack, addr %h", mem_first);
          mem_cnt = 0;
        end
      end
    end
  end

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && instr_valid) begin
        check("no_req_in_hold", {15'd0, mem_req}, 16'd0);
        if (instr_ready) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_empty: got ir %h, expected no transfer", ir);
          end else begin
            mon_e = sb.pop_front();
            check("ir", ir, mon_e.ir);
            check("n_ext", {14'd0, n_ext}, 16'(mon_e.n));
            if (mon_e.n >= 1) check("ext1", ext1, mon_e.e1);
            if (mon_e.n == 2) check("ext2", ext2, mon_e.e2);
            check("reg_PC_in", reg_PC_in, mon_e.next_pc);
          end
        end
      end
    end
  end

  initial begin
    int idx;
    bit found;
    rst = 1'b1; instr_ready = 1'b0; pc_load = 1'b0; pc_target = 16'h0; load_prev = 1'b0;
    load_tgt = 16'h0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[16'hFFFE >> 1] = 16'hC000;
    mem[16'hC000 >> 1] = 16'h4034; mem[16'hC002 >> 1] = 16'h1234;
    mem[16'hC004 >> 1] = 16'h4292; mem[16'hC006 >> 1] = 16'h0200;
    mem[16'hC008 >> 1] = 16'h0210; mem[16'hC00A >> 1] = 16'h4303;
    mem[16'hC00C >> 1] = 16'h4292; mem[16'hC00E >> 1] = 16'h0300;
    mem[16'hC010 >> 1] = 16'h0310; mem[16'hE000 >> 1] = 16'h4303;
    mem[16'hA000 >> 1] = 16'h4292; mem[16'hA002 >> 1] = 16'h0200;
    mem[16'hA004 >> 1] = 16'h0210;
    model_restart(mem[16'hFFFE >> 1]);

    #3 rst = 1'b0;
    #1;
    check("rst_mem_req", {15'd0, mem_req}, 16'd0);
    check("rst_mem_addr", mem_addr, 16'hFFFE);
    check("rst_pc", reg_PC_in, 16'h0000);
    check("rst_vec", RST_VEC, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_ir", ir, 16'h0000);
    check("rst_ext1", ext1, 16'h0000);
    check("rst_n_ext", {14'd0, n_ext}, 16'd0);

    step();
    rst = 1'b1;
    for (int i = 0; i < 40 && !(mem_req && mem_addr == 16'hC000); i++) begin
      step();
      drive(1'b0, 1'b0, 16'h0);
    end
    check("vec_captured", RST_VEC, 16'hC000);
    check("pc_after_vec", reg_PC_in, 16'hC000);
    check("first_req_addr", addr_log.size() > 0 ? addr_log[0] : 16'hxxxx, 16'hFFFE);
    check("second_req_addr", addr_log.size() > 1 ? addr_log[1] : 16'hxxxx, 16'hC000);

    wait_valid("first_instr", 40);
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b0, 1'b0, 16'h0);
      check("hold_req", {15'd0, mem_req}, 16'd0);
      check("hold_valid", {15'd0, instr_valid}, 16'd1);
      check("hold_ir", ir, 16'h4034);
    end
    step();
    drive(1'b1, 1'b0, 16'h0);
    step();
    drive(1'b1, 1'b0, 16'h0);
    check("op_req_after_ready", {15'd0, mem_req}, 16'd1);
    check("op_addr_after_ready", mem_addr, 16'hC004);

    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (mem_req && mem_addr == 16'hC00E && !mem_ack) begin
        found = 1'b1;
        break;
      end
      drive(1'b1, 1'b0, 16'h0);
    end
    if (!found) begin
      total++;
      $display("FAIL ext_req_wait: no pending request at C00E, expected one");
    end
    idx = addr_log.size();
    drive(1'b1, 1'b1, 16'hE001);
    for (int i = 0; i < 30 && addr_log.size() <= idx; i++) begin
      step();
      drive(1'b1, 1'b0, 16'h0);
    end
    check("redirect_addr", addr_log.size() > idx ? addr_log[idx] : 16'hxxxx, 16'hE000);

    for (int i = 0; i < 1500; i++) begin
      step();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 16'($urandom));
    end

    step();
    drive(1'b1, 1'b1, 16'hA000);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (mem_req && mem_addr == 16'hA002 && !mem_ack) begin
        found = 1'b1;
        break;
      end
      drive(1'b1, 1'b0, 16'h0);
    end
    if (!found) begin
      total++;
      $display("FAIL ext_req_wait2: no pending request at A002, expected one");
    end
    rst = 1'b0;
    pc_load = 1'b0;
    load_prev = 1'b0;
    #1;
    check("midrst_req", {15'd0, mem_req}, 16'd0);
    check("midrst_valid", {15'd0, instr_valid}, 16'd0);
    check("midrst_addr", mem_addr, 16'hFFFE);
    check("midrst_pc", reg_PC_in, 16'h0000);
    check("midrst_vec", RST_VEC, 16'h0000);
    model_restart(mem[16'hFFFE >> 1]);
    idx = addr_log.size();
    step();
    drive(1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    wait_valid("instr_after_rst", 40);
    check("refetch_vec_addr", addr_log.size() > idx ? addr_log[idx] : 16'hxxxx, 16'hFFFE);
    check("refetch_vec", RST_VEC, 16'hC000);
    for (int i = 0; i < 20; i++) begin
      step();
      drive(1'b1, 1'b0, 16'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
